// File: rtl/hazard_pkg.sv
// Shared types and helpers for the MIPS pipeline hazard controller.
package hazard_pkg;

  localparam int REG_W = 5;

  // Memory-access sequencer states.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // Forwarding mux select codes for the Execute-stage ALU operands.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_e;

  // True when a producer register matches a consumer register. $0 is hard-wired
  // to zero, so it never creates a dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] prod,
                                   input logic [REG_W-1:0] cons);
    return (prod != '0) && (prod == cons);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Pure-combinational forwarding comparators for the Decode compare operands
// and the Execute ALU operands.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs_d_i,
  input  logic [REG_W-1:0] rt_d_i,
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rt_e_i,
  input  logic [REG_W-1:0] write_reg_m_i,
  input  logic [REG_W-1:0] write_reg_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  output logic             fwd_a_d_o,
  output logic             fwd_b_d_o,
  output logic [1:0]       fwd_a_e_o,
  output logic [1:0]       fwd_b_e_o
);

  // Memory-stage result is younger than Writeback, so it takes priority.
  function automatic fwd_e fwd_sel(input logic [REG_W-1:0] src);
    if (reg_write_m_i && reg_hit(write_reg_m_i, src)) return FWD_M;
    if (reg_write_w_i && reg_hit(write_reg_w_i, src)) return FWD_W;
    return FWD_RF;
  endfunction

  // Operand selects for both stages, recomputed every cycle from stage fields.
  // NOTE: every always_comb output gets a value on every path, otherwise
  // synthesis infers a latch to hold the old value.
  always_comb begin
    fwd_a_e_o = fwd_sel(rs_e_i);
    fwd_b_e_o = fwd_sel(rt_e_i);
    fwd_a_d_o = reg_write_m_i && reg_hit(write_reg_m_i, rs_d_i);
    fwd_b_d_o = reg_write_m_i && reg_hit(write_reg_m_i, rt_d_i);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and branch
// stalls, multi-cycle data-memory sequencing with timeout, forwarding selects
// and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  RsD,
  input  logic [REG_W-1:0]  RtD,
  input  logic [REG_W-1:0]  RsE,
  input  logic [REG_W-1:0]  RtE,
  input  logic [REG_W-1:0]  WriteRegE,
  input  logic [REG_W-1:0]  WriteRegM,
  input  logic [REG_W-1:0]  WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushW,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MemTimeout,
  output logic [PERF_W-1:0] StallCycles
);

  localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_e            state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic lwstall, brstall, memstall, err;
  logic stall_fd, stall_em, flush_e, flush_w;

  hazard_fwd_unit u_fwd (
    .rs_d_i        (RsD),
    .rt_d_i        (RtD),
    .rs_e_i        (RsE),
    .rt_e_i        (RtE),
    .write_reg_m_i (WriteRegM),
    .write_reg_w_i (WriteRegW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_a_d_o     (ForwardAD),
    .fwd_b_d_o     (ForwardBD),
    .fwd_a_e_o     (ForwardAE),
    .fwd_b_e_o     (ForwardBE)
  );

  // Hazard detection and stall/flush combination; reset forces all controls
  // low so the pipeline registers clear instead of holding.
  always_comb begin
    lwstall  = MemtoRegE && (reg_hit(RtE, RsD) || reg_hit(RtE, RtD));
    brstall  = BranchD &&
               ((RegWriteE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD))) ||
                (MemtoRegM && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD))));
    memstall = MemReqM && !MemReadyM;
    err      = (state_q == ST_ERR);

    stall_fd = !reset && (lwstall || brstall || memstall || err);
    stall_em = !reset && (memstall || err);
    // A held Execute stage must keep its instruction, so never bubble it.
    flush_e  = !reset && (lwstall || brstall) && !memstall && !err;
    // While M is held, W must not re-commit the same instruction every cycle.
    flush_w  = stall_em;
  end

  assign StallF     = stall_fd;
  assign StallD     = stall_fd;
  assign StallE     = stall_em;
  assign StallM     = stall_em;
  assign FlushE     = flush_e;
  assign FlushW     = flush_w;
  assign MemTimeout = err;

  // Memory-access sequencer: counts not-ready cycles and latches a timeout.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          wait_cnt_q <= '0;
          if (memstall) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (MemReadyM) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q    <= ST_ERR;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        ST_ERR: begin
          wait_cnt_q <= '0;
        end
        default: begin
          state_q    <= ST_RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Next value of the stall-cycle counter, sticking at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fd && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int PERF_W   = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic clk, reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD;
  logic MemReqM, MemReadyM;
  logic StallF, StallD, FlushE, StallE, StallM, FlushW, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic MemTimeout;
  logic [PERF_W-1:0] StallCycles;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .StallE(StallE),
    .StallM(StallM), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MemTimeout(MemTimeout), .StallCycles(StallCycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timeout bookkeeping: an access that misses its first cycle becomes
  // "pending"; each further not-ready cycle adds to m_waited, and when the
  // MAX_WAIT-th pending cycle is also not ready the controller is dead.
  bit m_err, m_pending;
  int m_waited, m_stalls;

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic int m_fwd(input logic [4:0] src);
    if (RegWriteM && hit(WriteRegM, src)) return 2;
    if (RegWriteW && hit(WriteRegW, src)) return 1;
    return 0;
  endfunction

  function automatic bit m_lw();
    return MemtoRegE && (hit(RtE, RsD) || hit(RtE, RtD));
  endfunction

  function automatic bit m_br();
    return BranchD && ((RegWriteE && (hit(WriteRegE, RsD) || hit(WriteRegE, RtD))) ||
                       (MemtoRegM && (hit(WriteRegM, RsD) || hit(WriteRegM, RtD))));
  endfunction

  function automatic bit m_mem();
    return MemReqM && !MemReadyM;
  endfunction

  function automatic bit m_stall_f();
    return !reset && (m_lw() || m_br() || m_mem() || m_err);
  endfunction

  function automatic bit m_hold_em();
    return !reset && (m_mem() || m_err);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_err = 0; m_pending = 0; m_waited = 0; m_stalls = 0;
    end else begin
      if (m_stall_f() && m_stalls < PERF_MAX) m_stalls = m_stalls + 1;
      if (!m_err) begin
        if (!m_pending) begin
          m_pending = m_mem();
          m_waited  = 0;
        end else if (MemReadyM) begin
          m_pending = 0;
        end else if (m_waited + 1 == MAX_WAIT) begin
          m_err = 1; m_pending = 0;
        end else begin
          m_waited = m_waited + 1;
        end
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("m_StallF",    StallF,     m_stall_f());
    check("m_StallD",    StallD,     m_stall_f());
    check("m_StallE",    StallE,     m_hold_em());
    check("m_StallM",    StallM,     m_hold_em());
    check("m_FlushW",    FlushW,     m_hold_em());
    check("m_FlushE",    FlushE,     !reset && (m_lw() || m_br()) && !m_mem() && !m_err);
    check("m_FwdAE",     ForwardAE,  m_fwd(RsE));
    check("m_FwdBE",     ForwardBE,  m_fwd(RtE));
    check("m_FwdAD",     ForwardAD,  RegWriteM && hit(WriteRegM, RsD));
    check("m_FwdBD",     ForwardBD,  RegWriteM && hit(WriteRegM, RtD));
    check("m_Timeout",   MemTimeout, m_err);
    check("m_StallCyc",  StallCycles, m_stalls);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic pulse_reset();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    tick();
    tick();

    // Reset forces stall/flush low even with a live load-use hazard.
    MemtoRegE = 1; RtE = 2; RsD = 2;
    #1;
    check("rst_StallF", StallF, 0);
    check("rst_FlushE", FlushE, 0);
    check("rst_Timeout", MemTimeout, 0);
    check("rst_StallCyc", StallCycles, 0);
    clear_inputs();
    reset = 0;
    tick();

    // 1. Load-use: one stall + bubble, E not held.
    MemtoRegE = 1; RtE = 2; RsD = 2;
    #1;
    check("lu_StallF", StallF, 1);
    check("lu_StallD", StallD, 1);
    check("lu_FlushE", FlushE, 1);
    check("lu_StallE", StallE, 0);
    tick();
    MemtoRegE = 0; RtE = 0; RsD = 2;
    #1;
    check("lu_release", StallF, 0);
    check("lu_count", StallCycles, 1);
    // $0 never creates a dependency.
    MemtoRegE = 1; RtE = 0; RsD = 0;
    #1;
    check("lu_r0", StallF, 0);
    clear_inputs();

    // 2. Forwarding priority M over W, then W, then register file.
    RsE = 5; RtE = 5; WriteRegM = 5; WriteRegW = 5; RegWriteM = 1; RegWriteW = 1;
    #1;
    check("fw_AE_M", ForwardAE, 2'b10);
    check("fw_BE_M", ForwardBE, 2'b10);
    RegWriteM = 0;
    #1;
    check("fw_AE_W", ForwardAE, 2'b01);
    RsE = 0;
    #1;
    check("fw_AE_RF", ForwardAE, 2'b00);
    check("fw_BE_W", ForwardBE, 2'b01);
    tick();
    clear_inputs();

    // 3. Branch compare against an ALU result still in E, then forward from M.
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3;
    #1;
    check("br_StallF", StallF, 1);
    check("br_FlushE", FlushE, 1);
    check("br_StallE", StallE, 0);
    tick();
    RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 3; MemtoRegM = 0;
    #1;
    check("br_nostall", StallF, 0);
    check("br_FwdAD", ForwardAD, 1);
    check("br_FwdBD", ForwardBD, 0);
    MemtoRegM = 1;
    #1;
    check("br_load_M", StallF, 1);
    MemtoRegM = 0;
    tick();
    clear_inputs();

    // 4. Memory wait of 3 cycles; memstall beats a simultaneous load-use.
    pulse_reset();
    MemReqM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 2; RsD = 2;
    #1;
    check("mw_lu_FlushE", FlushE, 0);
    check("mw_lu_StallE", StallE, 1);
    MemtoRegE = 0; RtE = 0; RsD = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mw_StallM", StallM, 1);
      check("mw_FlushW", FlushW, 1);
      check("mw_FlushE", FlushE, 0);
      tick();
    end
    MemReadyM = 1;
    #1;
    check("mw_done_StallF", StallF, 0);
    check("mw_done_FlushW", FlushW, 0);
    tick();
    MemReqM = 0; MemReadyM = 0;
    #1;
    check("mw_count", StallCycles, 3);
    // Ready on the first request cycle: no stall at all.
    MemReqM = 1; MemReadyM = 1;
    #1;
    check("mw_fast_StallF", StallF, 0);
    tick();
    MemReqM = 0; MemReadyM = 0;
    #1;
    check("mw_fast_count", StallCycles, 3);

    // 5. Timeout: request + MAX_WAIT not-ready WAIT cycles latches the error.
    pulse_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++) tick();
    check("to_not_yet", MemTimeout, 0);
    tick();
    check("to_Timeout", MemTimeout, 1);
    MemReqM = 0; MemtoRegE = 1; RtE = 7; RsD = 7;
    #1;
    check("to_StallF", StallF, 1);
    check("to_StallM", StallM, 1);
    check("to_FlushE", FlushE, 0);
    MemReadyM = 1;
    tick();
    check("to_sticky", MemTimeout, 1);
    clear_inputs();
    reset = 1;
    #1;
    check("to_rst_StallF", StallF, 0);
    check("to_rst_FlushW", FlushW, 0);
    tick();
    reset = 0;
    #1;
    check("to_clr_Timeout", MemTimeout, 0);
    check("to_clr_StallE", StallE, 0);
    check("to_clr_count", StallCycles, 0);

    // 6. Counter saturation with a held load-use hazard.
    MemtoRegE = 1; RtE = 9; RtD = 9;
    for (int i = 0; i < 20; i++) tick();
    check("sat_count", StallCycles, 15);
    clear_inputs();
    tick();
    check("sat_hold", StallCycles, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
